// File: rtl/apb_pkg.sv
// Shared types for the two-master APB arbiter: FSM states and the latched
// request record. The record is sized to the package widths; the arbiter
// ports may be narrower and are zero-extended into it.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int STB_W      = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
    logic                  write;
    logic [STB_W-1:0]      stb;
  } apb_req;

endpackage

// File: rtl/apb_req_latch.sv
// Per-master setup-phase capture: holds the pending flag and a copy of the
// request so the master's bus is never re-sampled after its setup phase.
module apb_req_latch
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W
) (
  input  logic                    clk,
  input  logic                    rts,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pdata,
  input  logic [DATA_WIDTH/8-1:0] pstb,
  input  logic                    clear,
  output logic                    request,
  output apb_req                  req
);

  logic setup;
  logic pending;

  assign setup   = psel & ~penable;
  // A setup phase in the current cycle counts as a request immediately so the
  // arbiter can decide without waiting for the flag to register.
  assign request = pending | setup;

  // Pending flag: set by a setup phase, cleared when the transfer leaves ACCESS.
  always_ff @(posedge clk or posedge rts) begin
    if (rts)        pending <= 1'b0;
    else if (clear) pending <= 1'b0;
    else if (setup) pending <= 1'b1;
  end

  // Request register: only the first setup phase of a transfer is kept.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      req <= '0;
    end else if (setup && !pending) begin
      req <= '{addr:  APB_ADDR_W'(paddr),
               data:  APB_DATA_W'(pdata),
               write: pwrite,
               stb:   STB_W'(pstb)};
    end
  end

  // A master must not start another transfer while its previous one is queued.
  a_no_resetup: assert property (@(posedge clk) disable iff (rts) !(setup && pending));

endmodule

// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter. Each master's setup phase is latched,
// a round-robin winner is chosen in IDLE, and a clean SETUP/ACCESS sequence is
// replayed on the slave. The loser stalls in its access phase (no pready).
// An optional watchdog aborts hung slave accesses with perr.
//
//   state  | meaning
//   IDLE   | no transfer; pick a winner if any master is requesting
//   SETUP  | slave psel=1, penable=0 with the winner's request
//   ACCESS | slave psel=1, penable=1; wait for pready or watchdog
//   RESP   | one-cycle pready/prdata/perr to the winner
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rts,
  input  logic [ADDR_WIDTH-1:0]   m0_paddr,
  input  logic [ADDR_WIDTH-1:0]   m1_paddr,
  input  logic [DATA_WIDTH-1:0]   m0_pdata,
  input  logic [DATA_WIDTH-1:0]   m1_pdata,
  input  logic                    m0_psel,
  input  logic                    m0_penable,
  input  logic                    m0_pwrite,
  input  logic                    m1_psel,
  input  logic                    m1_penable,
  input  logic                    m1_pwrite,
  input  logic [DATA_WIDTH/8-1:0] m0_pstb,
  input  logic [DATA_WIDTH/8-1:0] m1_pstb,
  output logic [DATA_WIDTH-1:0]   m0_prdata,
  output logic [DATA_WIDTH-1:0]   m1_prdata,
  output logic                    m0_pready,
  output logic                    m1_pready,
  output logic                    m0_perr,
  output logic                    m1_perr,
  output logic [ADDR_WIDTH-1:0]   s_paddr,
  output logic [DATA_WIDTH-1:0]   s_pdata,
  output logic                    s_psel,
  output logic                    s_penable,
  output logic                    s_pwrite,
  output logic [DATA_WIDTH/8-1:0] s_pstb,
  input  logic [DATA_WIDTH-1:0]   s_prdata,
  input  logic                    s_pready,
  input  logic                    s_perr,
  output logic                    grant,
  output logic                    busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e            state, state_nxt;
  logic                  grant_nxt;
  logic                  prio;
  logic [1:0]            request;
  logic [1:0]            clear;
  apb_req                req [2];
  apb_req                win_req;
  logic                  drive;
  logic                  resp;
  logic                  done;
  logic                  tmo_hit;
  logic [CW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  perr_q;

  apb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_latch0 (
    .clk     (clk),
    .rts     (rts),
    .psel    (m0_psel),
    .penable (m0_penable),
    .pwrite  (m0_pwrite),
    .paddr   (m0_paddr),
    .pdata   (m0_pdata),
    .pstb    (m0_pstb),
    .clear   (clear[0]),
    .request (request[0]),
    .req     (req[0])
  );

  apb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_latch1 (
    .clk     (clk),
    .rts     (rts),
    .psel    (m1_psel),
    .penable (m1_penable),
    .pwrite  (m1_pwrite),
    .paddr   (m1_paddr),
    .pdata   (m1_pdata),
    .pstb    (m1_pstb),
    .clear   (clear[1]),
    .request (request[1]),
    .req     (req[1])
  );

  // The abort fires on the ACCESS cycle whose increment would reach TIMEOUT,
  // so the slave sees exactly TIMEOUT access cycles.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CW'(TIMEOUT - 1));

  // Next-state and arbitration decision.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    clear     = 2'b00;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (|request) begin
          state_nxt = SETUP;
          grant_nxt = (request == 2'b11) ? prio : request[1];
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (s_pready || tmo_hit) begin
          done      = 1'b1;
          clear     = grant ? 2'b10 : 2'b01;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave-side and master-side outputs decoded from state and the winner.
  always_comb begin
    win_req   = req[grant];
    drive     = (state == SETUP) || (state == ACCESS);
    resp      = (state == RESP);
    s_psel    = drive;
    s_penable = (state == ACCESS);
    s_paddr   = '0;
    s_pdata   = '0;
    s_pwrite  = 1'b0;
    s_pstb    = '0;
    if (drive) begin
      s_paddr  = win_req.addr[ADDR_WIDTH-1:0];
      s_pdata  = win_req.data[DATA_WIDTH-1:0];
      s_pwrite = win_req.write;
      s_pstb   = win_req.stb[DATA_WIDTH/8-1:0];
    end
    m0_pready = resp && !grant;
    m1_pready = resp && grant;
    m0_perr   = m0_pready && perr_q;
    m1_perr   = m1_pready && perr_q;
    m0_prdata = m0_pready ? rdata_q : '0;
    m1_prdata = m1_pready ? rdata_q : '0;
    busy      = (state != IDLE);
  end

  // State register, grant (changes only when leaving IDLE) and round-robin pointer.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      state <= IDLE;
      grant <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == RESP) prio <= ~grant;
    end
  end

  // Watchdog counter: cleared on SETUP entry, counts stalled ACCESS cycles, saturates.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      tmo_cnt <= '0;
    end else if (state == IDLE && state_nxt == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !s_pready && tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Response capture on ACCESS exit; a real pready takes precedence over abort.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else if (done) begin
      rdata_q <= s_pready ? s_prdata : '0;
      perr_q  <= s_pready ? s_perr : 1'b1;
    end
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-master to one-slave APB arbiter/bridge that shares the system APB slave bus between the CPU core (master 0) and a secondary requester such as debug or DMA (master 1).
- It latches each master's setup phase, arbitrates round-robin and replays a clean SETUP/ACCESS sequence on the slave side.
- It holds the losing master in its access phase by withholding pready.
- It adds an optional access-phase watchdog that terminates hung transfers with perr.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width; the strobe width is DATA_WIDTH/8.
- TIMEOUT, 256, maximum number of slave ACCESS cycles before abort. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, single domain.
- rts  in  1  reset, asynchronous, active-high.
- m0_paddr, m1_paddr  in  ADDR_WIDTH  master request address.
- m0_pdata, m1_pdata  in  DATA_WIDTH  master write data.
- m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite  in  1  master APB controls.
- m0_pstb, m1_pstb  in  DATA_WIDTH/8  master byte strobes.
- m0_prdata, m1_prdata  out  DATA_WIDTH  read data returned to the master.
- m0_pready, m1_pready, m0_perr, m1_perr  out  1  completion and error returned to the master.
- s_paddr  out  ADDR_WIDTH  slave address.
- s_pdata  out  DATA_WIDTH  slave write data.
- s_psel, s_penable, s_pwrite  out  1  slave APB controls.
- s_pstb  out  DATA_WIDTH/8  slave byte strobes.
- s_prdata  in  DATA_WIDTH  slave read data.
- s_pready, s_perr  in  1  slave completion and error.
- grant  out  1  index of the master currently owning the slave bus (debug).
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rts=1) puts every output and state element in a known value immediately:
  - FSM goes to IDLE; both pending flags clear; the round-robin pointer favours m0; the timeout counter clears.
  - s_psel=0, s_penable=0, s_pwrite=0, s_paddr=0, s_pdata=0, s_pstb=0.
  - m*_pready=0, m*_perr=0, m*_prdata=0, grant=0, busy=0.
- Reset mid-transfer abandons the transfer and issues no response. Masters are reset by the same rts.
- Request capture:
  - Master n's setup phase (mn_psel=1, mn_penable=0) sets pending[n].
  - The master's address, data, pwrite and pstb are latched into a per-master request register at that cycle.
  - The master must hold its signals stable through its access phase (APB rule); the arbiter never re-samples them.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any pending flag is set, select a winner and go to SETUP next cycle.
  - If both are pending, the master not granted last wins (round-robin). A single pending master always wins.
  - A setup phase arriving in the same cycle as the decision counts as pending in that cycle (bypass).
- SETUP: drive s_psel=1, s_penable=0 with the winner's latched request, then go to ACCESS.
- ACCESS:
  - Drive s_psel=1 and s_penable=1.
  - On s_pready=1: capture s_prdata and s_perr, clear pending[winner], go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT (if TIMEOUT≠0), abort: capture prdata=0 and perr=1, clear pending, go to RESP.
  - s_psel and s_penable drop to 0 on the exit cycle.
- RESP:
  - For exactly one cycle drive mn_pready=1, mn_prdata=captured data and mn_perr=captured error to the winner only.
  - Update the round-robin pointer, then go to IDLE.
  - If the other master is pending, it is selected at IDLE on the following cycle.
- Outside RESP, mn_pready=0 for both masters, so a master idling in its access phase stalls.
- Non-winner m*_prdata is forced to 0.
- Latency:
  - Minimum master-setup to master-pready is 4 cycles (capture → SETUP → ACCESS with pready → RESP).
  - Each extra slave wait state adds 1 cycle.
- pstb is passed through unchanged. Read strobes stay at whatever the master drove.
- A second setup phase from the same master while it is still pending is ignored. This is a protocol violation; flag it with an assertion.
- grant holds the last winner and changes only when leaving IDLE.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits wide, resets to 0 on each entry to SETUP, and saturates.

Decomposition:
- Shared package apb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, RESP);
  - an apb_req struct {addr, data, write, stb};
  - localparam STB_W = DATA_WIDTH/8.
- One sub-module, apb_req_latch, is instantiated twice: it captures the setup phase and holds the pending flag plus the request register.

Test Plan:
- m0 write to 0x1000, data 0xDEADBEEF, pstb 4'b1111, slave pready on first ACCESS cycle → s_psel seen 2 cycles, s_paddr=0x1000; m0_pready=1 exactly once, 4 cycles after m0 setup; m1_pready stays 0.
- m0 and m1 reads issued in the same cycle at 0x4 and 0x8, slave returns 0x11/0x22 → m0 served first (post-reset pointer), then m1; m1_prdata=0x22 with m1_pready; grant sequence 0 then 1.
- Back-to-back m0 requests while m1 is continuously pending → strict alternation m1, m0, m1; neither master starves.
- Slave holds pready=0 with TIMEOUT=8 → after 8 ACCESS cycles s_psel drops; the requester gets pready=1, perr=1, prdata=0; FSM returns to IDLE.
- Slave returns perr=1 on a write → perr is forwarded to the writing master only, with its pready.
- rts asserted asynchronously during ACCESS → s_psel, s_penable and busy go to 0 before the next clk edge; after release no stale pready is issued and a fresh m1 request completes normally.
